vedic_mul_sched: RTL and testbench

VEDIC_MUL_SCHED -- requirements
Module: vedic_mul_sched

---
 rtl/vedic_mul_sched.sv | 198 +++++++++++++++++++
 tb/tb_vedic_mul_sched.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vedic_mul_sched.sv
// ---------------------------------------------------------------------------
// vedic_mul_sched
//
// Purpose:
//   Time-shares one external combinational 4x4 multiplier between two
//   requesters. Each accepted 8x8 unsigned multiply is split into four
//   nibble partial products, as in Urdhva-Tiryagbhyam (vertical and
//   crosswise). They are issued on four consecutive cycles and summed into a
//   16-bit accumulator. A round-robin pointer decides which requester wins
//   when both are valid in the same idle cycle.
//
// Ports:
//   clk                   sole clock; all state updates on the rising edge
//   rst                   synchronous, active-high reset
//   req0_valid/a/b/ready  requester 0 handshake and 8-bit operands
//   req1_valid/a/b/ready  requester 1 handshake and 8-bit operands
//   mul_a, mul_b          4-bit operands driven to the external multiplier
//   mul_p                 8-bit product from the external multiplier
//   rsp_valid/id/p/ready  result handshake: owner id and 16-bit product
//   busy                  high whenever the scheduler is not idle
// ---------------------------------------------------------------------------
module vedic_mul_sched (
    input  logic        clk,
    input  logic        rst,

    input  logic        req0_valid,
    input  logic [7:0]  req0_a,
    input  logic [7:0]  req0_b,
    output logic        req0_ready,

    input  logic        req1_valid,
    input  logic [7:0]  req1_a,
    input  logic [7:0]  req1_b,
    output logic        req1_ready,

    output logic [3:0]  mul_a,
    output logic [3:0]  mul_b,
    input  logic [7:0]  mul_p,

    output logic        rsp_valid,
    output logic        rsp_id,
    output logic [15:0] rsp_p,
    input  logic        rsp_ready,

    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_e      state_q, state_d;
    logic [1:0]  step_q,  step_d;
    logic [15:0] acc_q,   acc_d;
    logic [7:0]  op_a_q,  op_a_d;
    logic [7:0]  op_b_q,  op_b_d;
    logic        id_q,    id_d;
    logic        rr_q,    rr_d;   // requester that wins the next tie

    // -----------------------------------------------------------------------
    // Arbitration
    // -----------------------------------------------------------------------
    // A lone valid always wins. A tie is broken by the round-robin pointer.
    // When any requester is valid, the winner is by construction valid, so
    // grant_any in IDLE is also the handshake condition.
    logic grant_any;
    logic grant_id;

    always_comb begin
        grant_any = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            grant_id = rr_q;
        end else begin
            grant_id = req1_valid;
        end
    end

    // -----------------------------------------------------------------------
    // Partial-product selection
    // -----------------------------------------------------------------------
    // step0 = lo*lo, step1 = hi(A)*lo(B), step2 = lo(A)*hi(B),
    // step3 = hi*hi. The A nibble follows step[0] and the B nibble follows
    // step[1]. The weight is 0, 4, 4 or 8 bits: 4 * (step[0] + step[1]).
    logic [3:0]  sel_a;
    logic [3:0]  sel_b;
    logic [15:0] partial;

    always_comb begin
        sel_a = step_q[0] ? op_a_q[7:4] : op_a_q[3:0];
        sel_b = step_q[1] ? op_b_q[7:4] : op_b_q[3:0];
        case (step_q)
            2'd0:    partial = {8'd0, mul_p};
            2'd1,
            2'd2:    partial = {4'd0, mul_p, 4'd0};
            default: partial = {mul_p, 8'd0};
        endcase
    end

    // -----------------------------------------------------------------------
    // Next-state and output logic
    // -----------------------------------------------------------------------
    // NOTE: every signal assigned in this block gets a default first. A path
    // that forgets to assign one would otherwise infer a latch.
    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        acc_d      = acc_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        id_d       = id_q;
        rr_d       = rr_q;

        req0_ready = 1'b0;
        req1_ready = 1'b0;
        mul_a      = 4'd0;
        mul_b      = 4'd0;
        rsp_valid  = 1'b0;
        rsp_id     = 1'b0;
        rsp_p      = 16'd0;
        busy       = (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                if (grant_any) begin
                    req0_ready = ~grant_id;
                    req1_ready =  grant_id;

                    op_a_d  = grant_id ? req1_a : req0_a;
                    op_b_d  = grant_id ? req1_b : req0_b;
                    id_d    = grant_id;
                    acc_d   = 16'd0;
                    step_d  = 2'd0;
                    rr_d    = ~grant_id;
                    state_d = ST_MUL;
                end
            end

            ST_MUL: begin
                mul_a  = sel_a;
                mul_b  = sel_b;
                // The sum of the four weighted 8-bit partials is exactly the
                // 8x8 product, so 16 bits cannot overflow.
                acc_d  = acc_q + partial;
                step_d = step_q + 2'd1;
                if (step_q == 2'd3) begin
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                // Readys stay low here, so a new accept can never share a
                // cycle with the response handshake.
                rsp_valid = 1'b1;
                rsp_id    = id_q;
                rsp_p     = acc_q;
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments. All flops update
    // together from values computed in the previous delta cycle, with no
    // ordering races between always blocks.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            step_q  <= 2'd0;
            acc_q   <= 16'd0;
            op_a_q  <= 8'd0;
            op_b_q  <= 8'd0;
            id_q    <= 1'b0;
            rr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            acc_q   <= acc_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            id_q    <= id_d;
            rr_q    <= rr_d;
        end
    end

endmodule

// File: tb/tb_vedic_mul_sched.sv
// ---------------------------------------------------------------------------
// tb_vedic_mul_sched
//
// Directed bench for vedic_mul_sched. The external 4x4 multiplier is modelled
// here as a plain combinational product. Expected values are hand-computed
// constants. Inputs change 1 time unit after a rising edge. Outputs are
// checked once the combinational logic has settled, well before the next
// edge.
// ---------------------------------------------------------------------------
module tb_vedic_mul_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic [7:0]  req0_a, req0_b, req1_a, req1_b;
    logic        req0_ready, req1_ready;
    logic [3:0]  mul_a, mul_b;
    logic [7:0]  mul_p;
    logic        rsp_valid, rsp_id, rsp_ready, busy;
    logic [15:0] rsp_p;

    int total_cnt = 0;
    int pass_cnt  = 0;
    int fail_cnt  = 0;

    always #5 clk = ~clk;

    assign mul_p = {4'd0, mul_a} * {4'd0, mul_b};

    vedic_mul_sched dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ready (req1_ready),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_p      (mul_p),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_p      (rsp_p),
        .rsp_ready  (rsp_ready),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge, then let outputs settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1'b1;
        req0_valid = 1'b0; req0_a = 8'h00; req0_b = 8'h00;
        req1_valid = 1'b0; req1_a = 8'h00; req1_b = 8'h00;
        rsp_ready = 1'b0;

        // ---------------- reset state ----------------
        tick(); tick();
        rst = 1'b0;
        settle();
        check("rst_busy",      32'(busy),       32'h0);
        check("rst_rsp_valid", 32'(rsp_valid),  32'h0);
        check("rst_rsp_id",    32'(rsp_id),     32'h0);
        check("rst_rsp_p",     32'(rsp_p),      32'h0);
        check("rst_mul_a",     32'(mul_a),      32'h0);
        check("rst_mul_b",     32'(mul_b),      32'h0);
        check("rst_ready0",    32'(req0_ready), 32'h0);
        check("rst_ready1",    32'(req1_ready), 32'h0);

        // ---------------- max operands: FF*FF ----------------
        req0_valid = 1'b1; req0_a = 8'hFF; req0_b = 8'hFF;
        settle();
        check("max_ready0", 32'(req0_ready), 32'h1);
        check("max_ready1", 32'(req1_ready), 32'h0);
        tick();                                   // T+1: MUL step0
        req0_valid = 1'b0;
        settle();
        check("max_busy",  32'(busy),  32'h1);
        check("max_mul_a", 32'(mul_a), 32'hF);
        check("max_mul_b", 32'(mul_b), 32'hF);
        tick(); tick(); tick();                   // T+4: MUL step3
        check("max_no_rsp_t4", 32'(rsp_valid), 32'h0);
        tick();                                   // T+5: DONE
        check("max_rsp_valid_t5", 32'(rsp_valid), 32'h1);
        check("max_rsp_p",        32'(rsp_p),     32'hFE01);
        check("max_rsp_id",       32'(rsp_id),    32'h0);
        check("max_mul_a_done",   32'(mul_a),     32'h0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        settle();
        check("max_idle_busy",  32'(busy),      32'h0);
        check("max_idle_valid", 32'(rsp_valid), 32'h0);

        // ---------------- simultaneous requests ----------------
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req0_valid = 1'b1; req0_a = 8'h0D; req0_b = 8'h0B;
        req1_valid = 1'b1; req1_a = 8'h12; req1_b = 8'h34;
        settle();
        check("sim_ready0", 32'(req0_ready), 32'h1);
        check("sim_ready1", 32'(req1_ready), 32'h0);
        tick();
        req0_valid = 1'b0;
        settle();
        check("sim_ready1_mul", 32'(req1_ready), 32'h0);
        tick(); tick(); tick(); tick();           // DONE
        check("sim_first_valid", 32'(rsp_valid),  32'h1);
        check("sim_first_id",    32'(rsp_id),     32'h0);
        check("sim_first_p",     32'(rsp_p),      32'h008F);
        check("sim_ready1_done", 32'(req1_ready), 32'h0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        settle();
        check("sim_ready1_idle", 32'(req1_ready), 32'h1);
        tick();
        req1_valid = 1'b0;
        tick(); tick(); tick(); tick();
        check("sim_second_valid", 32'(rsp_valid), 32'h1);
        check("sim_second_id",    32'(rsp_id),    32'h1);
        check("sim_second_p",     32'(rsp_p),     32'h03A8);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // ---------------- step sequence: 3C*A7 ----------------
        req0_valid = 1'b1; req0_a = 8'h3C; req0_b = 8'hA7;
        settle();
        check("seq_ready0", 32'(req0_ready), 32'h1);
        tick();
        req0_valid = 1'b0;
        settle();
        check("seq_s0", {24'd0, mul_a, mul_b}, 32'hC7);
        tick();
        check("seq_s1", {24'd0, mul_a, mul_b}, 32'h37);
        tick();
        check("seq_s2", {24'd0, mul_a, mul_b}, 32'hCA);
        tick();
        check("seq_s3", {24'd0, mul_a, mul_b}, 32'h3A);
        tick();
        check("seq_rsp_p", 32'(rsp_p), 32'h2724);

        // ---------------- backpressure in DONE ----------------
        req0_valid = 1'b1; req0_a = 8'h11; req0_b = 8'h22;
        req1_valid = 1'b1; req1_a = 8'h33; req1_b = 8'h44;
        settle();
        for (int i = 0; i < 3; i++) begin
            check("bp_valid",  32'(rsp_valid),  32'h1);
            check("bp_p",      32'(rsp_p),      32'h2724);
            check("bp_id",     32'(rsp_id),     32'h0);
            check("bp_ready0", 32'(req0_ready), 32'h0);
            check("bp_ready1", 32'(req1_ready), 32'h0);
            check("bp_busy",   32'(busy),       32'h1);
            tick();
        end
        rsp_ready = 1'b1;
        settle();
        check("bp_ready0_rsp_hs", 32'(req0_ready), 32'h0);
        check("bp_ready1_rsp_hs", 32'(req1_ready), 32'h0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
        rsp_ready = 1'b0;
        settle();
        check("bp_idle_busy",  32'(busy),      32'h0);
        check("bp_idle_valid", 32'(rsp_valid), 32'h0);

        // ---------------- reset mid-operation ----------------
        req0_valid = 1'b1; req0_a = 8'h3C; req0_b = 8'hA7;
        settle();
        tick();                                   // step0
        req0_valid = 1'b0;
        tick();                                   // step1
        tick();                                   // step2
        check("abort_s2", {24'd0, mul_a, mul_b}, 32'hCA);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        settle();
        check("abort_busy",  32'(busy),      32'h0);
        check("abort_valid", 32'(rsp_valid), 32'h0);
        check("abort_p",     32'(rsp_p),     32'h0);
        check("abort_mul",   {24'd0, mul_a, mul_b}, 32'h0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("abort_no_rsp", 32'(rsp_valid), 32'h0);
        end

        // ---------------- req1-only request, zero operand ----------------
        req1_valid = 1'b1; req1_a = 8'h00; req1_b = 8'hA5;
        settle();
        check("zero_ready1", 32'(req1_ready), 32'h1);
        check("zero_ready0", 32'(req0_ready), 32'h0);
        tick();
        req1_valid = 1'b0;
        tick(); tick(); tick(); tick();
        check("zero_valid", 32'(rsp_valid), 32'h1);
        check("zero_id",    32'(rsp_id),    32'h1);
        check("zero_p",     32'(rsp_p),     32'h0000);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // ---------------- reset beats a handshake ----------------
        req0_valid = 1'b1; req0_a = 8'h05; req0_b = 8'h07;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req0_valid = 1'b0;
        settle();
        check("rstprio_busy", 32'(busy), 32'h0);
        tick();
        check("rstprio_still_idle", 32'(busy), 32'h0);

        if (fail_cnt != 0) $display("%0d checks did not match", fail_cnt);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    // Hard stop in case the sequence above ever stalls.
    initial begin
        #20000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
